// File: rtl/gpr_file.sv
// Integer register file with write-first bypass and a pending-write
// scoreboard used to stall on RAW/WAW hazards.
module gpr_file #(
  parameter int ISA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_NUM        = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic [ISA_WIDTH-1:0]      src1,
  output logic [ISA_WIDTH-1:0]      src2,
  output logic                      src1_ready,
  output logic                      src2_ready,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  output logic                      issue_waw,
  input  logic                      gpr_wen,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic [ISA_WIDTH-1:0]      srd,
  output logic [REG_NUM-1:0]        busy_vec
);

  typedef logic [REG_ADDR_WIDTH-1:0] addr_t;

  logic [ISA_WIDTH-1:0] regs [1:REG_NUM-1];
  logic [REG_NUM-1:0]   busy;
  logic [REG_NUM-1:0]   busy_nxt;

  logic [ISA_WIDTH-1:0] rf1, rf2;
  logic bz1, bz2, bzi;
  logic nz1, nz2, nzi;
  logic byp1, byp2, bypi;

  // Out-of-range indices match no entry, so they read 0 and are never busy.
  always_comb begin
    rf1 = '0;
    rf2 = '0;
    bz1 = 1'b0;
    bz2 = 1'b0;
    bzi = 1'b0;
    for (int i = 1; i < REG_NUM; i++) begin
      if (rs1_addr == addr_t'(i)) begin
        rf1 = regs[i];
        bz1 = busy[i];
      end
      if (rs2_addr == addr_t'(i)) begin
        rf2 = regs[i];
        bz2 = busy[i];
      end
      if (issue_rd == addr_t'(i)) begin
        bzi = busy[i];
      end
    end
  end

  assign nz1  = (rs1_addr != '0);
  assign nz2  = (rs2_addr != '0);
  assign nzi  = (issue_rd != '0);
  assign byp1 = gpr_wen && (rd_addr == rs1_addr);
  assign byp2 = gpr_wen && (rd_addr == rs2_addr);
  assign bypi = gpr_wen && (rd_addr == issue_rd);

  assign src1 = !nz1 ? '0 : (byp1 ? srd : rf1);
  assign src2 = !nz2 ? '0 : (byp2 ? srd : rf2);

  assign src1_ready = !nz1 || !bz1 || byp1;
  assign src2_ready = !nz2 || !bz2 || byp2;

  assign issue_waw = issue_valid && nzi && bzi && !bypi;

  // Set after clear so a fresh producer wins over a retiring one.
  always_comb begin
    busy_nxt = busy;
    for (int i = 1; i < REG_NUM; i++) begin
      if (gpr_wen && (rd_addr == addr_t'(i)))
        busy_nxt[i] = 1'b0;
      if (issue_valid && !issue_waw && (issue_rd == addr_t'(i)))
        busy_nxt[i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < REG_NUM; i++)
        regs[i] <= '0;
      busy <= '0;
    end else begin
      busy <= busy_nxt;
      for (int i = 1; i < REG_NUM; i++)
        if (gpr_wen && (rd_addr == addr_t'(i)))
          regs[i] <= srd;
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: scenario tasks with a queue of
// expected read data filled at drive time and drained at sample time.
module tb_gpr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] src1, src2;
  logic        src1_ready, src2_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_waw;
  logic        gpr_wen;
  logic [4:0]  rd_addr;
  logic [31:0] srd;
  logic [31:0] busy_vec;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp;

  gpr_file dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .src1(src1), .src2(src2),
    .src1_ready(src1_ready), .src2_ready(src2_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_waw(issue_waw),
    .gpr_wen(gpr_wen), .rd_addr(rd_addr), .srd(srd),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    gpr_wen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;
    gpr_wen = 1'b0; rd_addr = 5'd0; srd = '0;
    #3;
    checks++;
    if (busy_vec !== 32'h0 || issue_waw !== 1'b0) begin
      errors++;
      $display("FAIL in_reset busy=%h waw=%b exp busy=0 waw=0",
               busy_vec, issue_waw);
    end
    step();
    rst = 1'b1;
    step();
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i + 1);
      exp_q.push_back(32'h0);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (src1 !== exp || src2 !== exp || src1_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_read x%0d src1=%h src2=%h rdy=%b exp 0/1",
                 i, src1, src2, src1_ready);
      end
    end
    checks++;
    if (busy_vec !== 32'h0) begin
      errors++;
      $display("FAIL reset_busy got=%h exp=0", busy_vec);
    end
  endtask

  task automatic test_write_bypass();
    gpr_wen = 1'b1; rd_addr = 5'd5; srd = 32'hDEADBEEF;
    rs1_addr = 5'd5;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (src1 !== exp || src1_ready !== 1'b1) begin
      errors++;
      $display("FAIL bypass_same got=%h exp=%h", src1, exp);
    end
    step();
    idle();
    srd = 32'h0;
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (src1 !== exp) begin
      errors++;
      $display("FAIL write_next got=%h exp=%h", src1, exp);
    end
    gpr_wen = 1'b1; rd_addr = 5'd0; srd = 32'h1234;
    rs1_addr = 5'd0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (src1 !== exp) begin
      errors++;
      $display("FAIL x0_same got=%h exp=%h", src1, exp);
    end
    step();
    idle();
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (src1 !== exp || busy_vec !== 32'h0) begin
      errors++;
      $display("FAIL x0_after got=%h busy=%h exp 0", src1, busy_vec);
    end
  endtask

  task automatic test_raw();
    issue_valid = 1'b1; issue_rd = 5'd7; rs2_addr = 5'd7;
    #1;
    checks++;
    if (src2_ready !== 1'b1 || issue_waw !== 1'b0) begin
      errors++;
      $display("FAIL raw_issue_cycle rdy=%b waw=%b exp 1/0",
               src2_ready, issue_waw);
    end
    step();
    idle();
    #1;
    checks++;
    if (src2_ready !== 1'b0 || busy_vec !== 32'h80) begin
      errors++;
      $display("FAIL raw_stall rdy=%b busy=%h exp 0/00000080",
               src2_ready, busy_vec);
    end
    step();
    step();
    gpr_wen = 1'b1; rd_addr = 5'd7; srd = 32'h55;
    exp_q.push_back(32'h55);
    exp_q.push_back(32'h55);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (src2 !== exp || src2_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_wb_cycle got=%h rdy=%b exp %h/1",
               src2, src2_ready, exp);
    end
    step();
    idle();
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (src2 !== exp || busy_vec !== 32'h0 || src2_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_after got=%h busy=%h exp %h/0",
               src2, busy_vec, exp);
    end
  endtask

  task automatic test_waw();
    issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    #1;
    checks++;
    if (issue_waw !== 1'b1) begin
      errors++;
      $display("FAIL waw_hold got=%b exp=1", issue_waw);
    end
    step();
    idle();
    #1;
    checks++;
    if (busy_vec !== 32'h8) begin
      errors++;
      $display("FAIL waw_busy got=%h exp=00000008", busy_vec);
    end
    issue_valid = 1'b1; issue_rd = 5'd3;
    gpr_wen = 1'b1; rd_addr = 5'd3; srd = 32'h33;
    #1;
    checks++;
    if (issue_waw !== 1'b0) begin
      errors++;
      $display("FAIL waw_wb_same got=%b exp=0", issue_waw);
    end
    step();
    idle();
    rs1_addr = 5'd3;
    exp_q.push_back(32'h33);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (busy_vec !== 32'h8 || src1 !== exp || src1_ready !== 1'b0) begin
      errors++;
      $display("FAIL set_wins busy=%h src1=%h rdy=%b exp 8/%h/0",
               busy_vec, src1, src1_ready, exp);
    end
    gpr_wen = 1'b1; rd_addr = 5'd3; srd = 32'h34;
    step();
    idle();
    #1;
    checks++;
    if (busy_vec !== 32'h0) begin
      errors++;
      $display("FAIL waw_drain got=%h exp=0", busy_vec);
    end
  endtask

  task automatic test_async_reset();
    issue_valid = 1'b1; issue_rd = 5'd9;
    gpr_wen = 1'b1; rd_addr = 5'd9; srd = 32'hA5;
    step();
    idle();
    rs1_addr = 5'd9;
    exp_q.push_back(32'hA5);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (src1 !== exp || busy_vec !== 32'h200) begin
      errors++;
      $display("FAIL pre_reset src1=%h busy=%h exp %h/00000200",
               src1, busy_vec, exp);
    end
    #1;
    rst = 1'b0;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (src1 !== exp || busy_vec !== 32'h0 || src1_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset src1=%h busy=%h rdy=%b exp 0/0/1",
               src1, busy_vec, src1_ready);
    end
    gpr_wen = 1'b1; rd_addr = 5'd10; srd = 32'hFF;
    rs1_addr = 5'd10;
    exp_q.push_back(32'hFF);
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (src1 !== exp) begin
      errors++;
      $display("FAIL reset_bypass got=%h exp=%h", src1, exp);
    end
    step();
    idle();
    rst = 1'b1;
    step();
    exp = exp_q.pop_front();
    checks++;
    if (src1 !== exp) begin
      errors++;
      $display("FAIL reset_discard got=%h exp=%h", src1, exp);
    end
  endtask

  task automatic test_dual_read();
    gpr_wen = 1'b1; rd_addr = 5'd4; srd = 32'h77;
    step();
    idle();
    rs1_addr = 5'd4; rs2_addr = 5'd4;
    exp_q.push_back(32'h77);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (src1 !== exp || src2 !== exp) begin
      errors++;
      $display("FAIL dual_read src1=%h src2=%h exp=%h", src1, src2, exp);
    end
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    checks++;
    if (issue_waw !== 1'b0) begin
      errors++;
      $display("FAIL x0_issue_waw got=%b exp=0", issue_waw);
    end
    step();
    idle();
    #1;
    checks++;
    if (busy_vec !== 32'h0) begin
      errors++;
      $display("FAIL x0_issue_busy got=%h exp=0", busy_vec);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 1; i < 32; i++) begin
      v = $urandom();
      gpr_wen = 1'b1; rd_addr = 5'(i); srd = v;
      rs1_addr = 5'(i);
      #1;
      checks++;
      if (src1 !== v) begin
        errors++;
        $display("FAIL b2b_bypass x%0d got=%h exp=%h", i, src1, v);
      end
      exp_q.push_back(v);
      step();
    end
    idle();
    for (int i = 1; i < 32; i++) begin
      rs2_addr = 5'(i);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (src2 !== exp || src2_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_read x%0d got=%h exp=%h", i, src2, exp);
      end
    end
    checks++;
    if (exp_q.size() != 0 || busy_vec !== 32'h0) begin
      errors++;
      $display("FAIL b2b_drain q=%0d busy=%h exp 0/0",
               exp_q.size(), busy_vec);
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_raw();
    test_waw();
    test_async_reset();
    test_dual_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
